// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parameterised serial master: addr/data frame out, slave wait, read data in
// Optional wait-state timeout is compiled in when SPI_MASTER_TIMEOUT_EN is defined.
module spi_master_param #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              cs,
  output logic              mosi,
  input  logic              miso,
  input  logic              ready,
  input  logic              op_done
);

  localparam int FRM_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_RD_BIT = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_WR_BIT = CNT_W'(ADDR_W + DATA_W);
  localparam logic [CNT_W-1:0] LAST_RX_BIT = CNT_W'(DATA_W - 1);
  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_RANGE = 2'b01;

  if (DEPTH < 1 || TMO_CYC < 1) begin : g_param_check
    $error("spi_master_param: DEPTH and TMO_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SHIFT, S_WR_WAIT, S_RD_WAIT, S_RD_DATA, S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr;
  logic [FRM_W-1:0]   r_frame;
  logic [DATA_W-1:0]  r_rx;
  logic [DATA_W-1:0]  r_dout;
  logic [1:0]         r_err_code;
  logic [ADDR_W:0]    w_addr_ext;
  logic               w_range_err;
  logic               w_frame_end;
  logic               w_rx_last;
  logic               w_cnt_en;
  logic [DATA_W-1:0]  w_rx_nxt;

  // Frame is {din, addr, wr}; bit 0 is always the one on mosi and shifts out LSB-first.
  assign w_addr_ext  = {1'b0, r_frame[ADDR_W:1]};
  assign w_range_err = (w_addr_ext >= (ADDR_W+1)'(DEPTH));
  assign w_frame_end = (r_cnt == (r_wr ? LAST_WR_BIT : LAST_RD_BIT));
  assign w_rx_last   = (r_cnt == LAST_RX_BIT);
  assign w_cnt_en    = (r_state == S_SHIFT) || (r_state == S_RD_DATA);
  assign w_rx_nxt    = {miso, r_rx[DATA_W-1:1]};

`ifdef SPI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [1:0] EC_TMO = 2'b10;

  logic [TMO_W-1:0] r_tmo;
  logic             w_waiting;
  logic             w_tmo_hit;

  assign w_waiting = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
  // A slave response arriving on the final wait cycle still wins over the timeout.
  assign w_tmo_hit = w_waiting && (r_tmo == TMO_LAST) &&
                     !((r_state == S_WR_WAIT) ? op_done : ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= (!w_waiting || (w_state_nxt != r_state)) ? '0 : r_tmo + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (req) w_state_nxt = S_CHECK;
      S_CHECK:   w_state_nxt = w_range_err ? S_FINISH : S_SHIFT;
      S_SHIFT:   if (w_frame_end) w_state_nxt = r_wr ? S_WR_WAIT : S_RD_WAIT;
      S_WR_WAIT: begin
        if (op_done) w_state_nxt = S_FINISH;
`ifdef SPI_MASTER_TIMEOUT_EN
        else if (w_tmo_hit) w_state_nxt = S_FINISH;
`endif
      end
      S_RD_WAIT: begin
        if (ready) w_state_nxt = S_RD_DATA;
`ifdef SPI_MASTER_TIMEOUT_EN
        else if (w_tmo_hit) w_state_nxt = S_FINISH;
`endif
      end
      S_RD_DATA: if (w_rx_last) w_state_nxt = S_FINISH;
      S_FINISH:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_FINISH);
    err  = (r_state == S_FINISH) && (r_err_code != EC_NONE);
    cs   = (r_state != S_SHIFT);
    mosi = (r_state == S_SHIFT) && r_frame[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_frame    <= '0;
      r_rx       <= '0;
      r_dout     <= '0;
      r_err_code <= EC_NONE;
    end else begin
      r_cnt <= (!w_cnt_en || (w_state_nxt != r_state)) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_wr       <= wr;
            r_frame    <= {din, addr, wr};
            r_err_code <= EC_NONE;
          end
        end
        S_CHECK: begin
          if (w_range_err) r_err_code <= EC_RANGE;
        end
        S_SHIFT: begin
          r_frame <= {1'b0, r_frame[FRM_W-1:1]};
        end
        S_RD_DATA: begin
          r_rx <= w_rx_nxt;
          if (w_rx_last) r_dout <= w_rx_nxt;
        end
`ifdef SPI_MASTER_TIMEOUT_EN
        S_WR_WAIT, S_RD_WAIT: begin
          if (w_tmo_hit) r_err_code <= EC_TMO;
        end
`endif
        default: ;
      endcase
    end
  end

  assign dout     = r_dout;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - directed bench for spi_master_param (default and wide instances)
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst, req_d, wr_d, miso, ready, op_done, sel;
  logic [31:0] addr_d, din_d;

  logic [7:0]  dout1;
  logic        busy1, done1, err1, cs1, mosi1;
  logic [1:0]  ec1;
  logic [15:0] dout2;
  logic        busy2, done2, err2, cs2, mosi2;
  logic [1:0]  ec2;

  logic [31:0] o_dout;
  logic        o_busy, o_done, o_err, o_cs, o_mosi;
  logic [1:0]  o_ec;

  int n_cmp = 0;
  int n_bad = 0;

  int          res_cs_n, res_done_k, res_post;
  logic [31:0] res_bits;
  logic        res_err, res_busy1, res_busy_after;

  always #5 clk = ~clk;

  spi_master_param #(.TMO_CYC(10)) u_dut (
    .clk(clk), .rst(rst), .req(req_d & ~sel), .wr(wr_d), .addr(addr_d[7:0]), .din(din_d[7:0]),
    .dout(dout1), .busy(busy1), .done(done1), .err(err1), .err_code(ec1),
    .cs(cs1), .mosi(mosi1), .miso(miso), .ready(ready), .op_done(op_done)
  );

  spi_master_param #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024), .TMO_CYC(10)) u_wide (
    .clk(clk), .rst(rst), .req(req_d & sel), .wr(wr_d), .addr(addr_d[9:0]), .din(din_d[15:0]),
    .dout(dout2), .busy(busy2), .done(done2), .err(err2), .err_code(ec2),
    .cs(cs2), .mosi(mosi2), .miso(miso), .ready(ready), .op_done(op_done)
  );

  assign o_dout = sel ? {16'h0, dout2} : {24'h0, dout1};
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;
  assign o_err  = sel ? err2  : err1;
  assign o_cs   = sel ? cs2   : cs1;
  assign o_mosi = sel ? mosi2 : mosi1;
  assign o_ec   = sel ? ec2   : ec1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction and plays the slave: response after dly post-frame cycles,
  // read data LSB-first starting the cycle after ready.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input int dw, input int dly, input bit poke);
    int  pc;
    bit  seen_low;
    pc = 0;
    seen_low = 0;
    res_cs_n = 0; res_bits = '0; res_done_k = -1; res_post = -1; res_err = 1'bx;
    @(negedge clk);
    req_d = 1'b1; wr_d = w; addr_d = a; din_d = d;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_d = 1'b0;
        res_busy1 = o_busy;
      end
      if (poke && k == 4) begin
        req_d = 1'b1; wr_d = 1'b0; addr_d = '0;
      end else if (poke && k == 5) begin
        req_d = 1'b0;
      end
      if (!o_cs) begin
        if (res_cs_n < 32) res_bits[res_cs_n] = o_mosi;
        res_cs_n++;
        seen_low = 1;
      end
      if (o_done) begin
        res_done_k = k;
        res_err = o_err;
        res_post = seen_low ? pc : -1;
        break;
      end
      op_done = 1'b0;
      ready = 1'b0;
      if (o_cs && seen_low) begin
        if (pc == dly) begin
          op_done = w;
          ready = !w;
        end
        if (pc > dly && pc <= dly + dw) miso = rdata[pc-dly-1];
        pc++;
      end
    end
    op_done = 1'b0; ready = 1'b0; miso = 1'b0; req_d = 1'b0;
    @(negedge clk);
    res_busy_after = o_busy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_low, n_done, n_busy;
    logic [31:0] exp_bits;
    rst = 1'b0; req_d = 1'b0; wr_d = 1'b0; addr_d = '0; din_d = '0;
    miso = 1'b0; ready = 1'b0; op_done = 1'b0; sel = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cs", o_cs, 1);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ec", o_ec, 0);
    chk("rst_dout", o_dout, 0);
    rst = 1'b1;

    // write addr=5 din=A3: mosi 1,1,0,1,0,0,0,0,0,1,1,0,0,0,1,0,1
    do_txn(1'b1, 32'd5, 32'hA3, 32'h0, 8, 0, 0);
    chk("wr5_cs_cycles", res_cs_n, 17);
    chk("wr5_bits", res_bits, 32'h0001460B);
    chk("wr5_busy_first", res_busy1, 1);
    chk("wr5_done_k", res_done_k, 20);
    chk("wr5_post", res_post, 1);
    chk("wr5_err", res_err, 0);
    chk("wr5_ec", o_ec, 0);
    chk("wr5_busy_after", res_busy_after, 0);
    chk("wr5_dout", o_dout, 0);

    do_txn(1'b0, 32'd5, 32'h0, 32'hA3, 8, 0, 0);
    chk("rd5_cs_cycles", res_cs_n, 9);
    chk("rd5_bits", res_bits, 32'h0000000A);
    chk("rd5_done_k", res_done_k, 20);
    chk("rd5_post", res_post, 9);
    chk("rd5_err", res_err, 0);
    chk("rd5_dout", o_dout, 32'hA3);
    chk("rd5_busy_after", res_busy_after, 0);

    do_txn(1'b1, 32'd40, 32'h11, 32'h0, 8, 0, 0);
    chk("wr40_cs_cycles", res_cs_n, 0);
    chk("wr40_done_k", res_done_k, 2);
    chk("wr40_err", res_err, 1);
    chk("wr40_ec", o_ec, 1);
    chk("wr40_dout", o_dout, 32'hA3);

    // DEPTH-1 is the last legal address
    do_txn(1'b1, 32'd31, 32'h00, 32'h0, 8, 0, 0);
    chk("wr31_cs_cycles", res_cs_n, 17);
    chk("wr31_err", res_err, 0);
    chk("wr31_ec_cleared", o_ec, 0);

    // slave withholds ready for 30 wait cycles
    do_txn(1'b0, 32'd6, 32'h0, 32'h5C, 8, 30, 0);
    chk("rdslow_cs_cycles", res_cs_n, 9);
    chk("rdslow_cs_end", o_cs, 1);
`ifdef SPI_MASTER_TIMEOUT_EN
    chk("rdslow_post", res_post, 10);
    chk("rdslow_err", res_err, 1);
    chk("rdslow_ec", o_ec, 2);
    chk("rdslow_dout", o_dout, 32'hA3);
`else
    chk("rdslow_post", res_post, 39);
    chk("rdslow_err", res_err, 0);
    chk("rdslow_ec", o_ec, 0);
    chk("rdslow_dout", o_dout, 32'h5C);
`endif

    // reset in the middle of a write frame
    @(negedge clk);
    req_d = 1'b1; wr_d = 1'b1; addr_d = 32'd7; din_d = 32'h55;
    @(negedge clk);
    req_d = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_pre_cs", o_cs, 0);
    rst = 1'b0;
    #1;
    chk("midrst_cs", o_cs, 1);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_mosi", o_mosi, 0);
    chk("midrst_dout", o_dout, 0);
    chk("midrst_ec", o_ec, 0);
    @(negedge clk);
    rst = 1'b1;
    n_low = 0; n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!o_cs) n_low++;
      if (o_done) n_done++;
    end
    chk("postrst_cs_low", n_low, 0);
    chk("postrst_done", n_done, 0);

    do_txn(1'b1, 32'd3, 32'h3C, 32'h0, 8, 0, 0);
    exp_bits = {15'h0, 8'h3C, 8'd3, 1'b1};
    chk("wr3_cs_cycles", res_cs_n, 17);
    chk("wr3_bits", res_bits, exp_bits);
    chk("wr3_done_k", res_done_k, 20);
    chk("wr3_err", res_err, 0);
    chk("wr3_dout", o_dout, 0);

    // wide instance: 27-bit frame, request during busy must be ignored
    sel = 1'b1;
    do_txn(1'b1, 32'd1023, 32'hBEEF, 32'h0, 16, 0, 1);
    exp_bits = {5'h0, 16'hBEEF, 10'h3FF, 1'b1};
    chk("wide_cs_cycles", res_cs_n, 27);
    chk("wide_bits", res_bits, exp_bits);
    chk("wide_done_k", res_done_k, 30);
    chk("wide_err", res_err, 0);
    chk("wide_ec", o_ec, 0);
    chk("wide_busy_after", res_busy_after, 0);
    n_low = 0; n_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!o_cs) n_low++;
      if (o_busy) n_busy++;
    end
    chk("wide_poke_cs", n_low, 0);
    chk("wide_poke_busy", n_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
